// File: rtl/fetch_unit.sv
// Fetch stage: program counter, instruction register and return-address stack.
// Drives the program-memory address straight from the PC register and
// registers the returned word. Each cycle it hands decode one instruction
// or one bubble.
module fetch_unit #(
  parameter  int WIDTH     = 16,
  parameter  int ELEMENTOS = 1024,
  parameter  int DEPTH     = 8,
  localparam int AW        = $clog2(ELEMENTOS)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [AW-1:0]    pc_addr,
  input  logic [WIDTH-1:0] mem_rd,
  input  logic             stall,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic [AW-1:0]    target,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic [AW-1:0]    ir_pc,
  output logic             stk_overflow,
  output logic             stk_underflow
);

  // Stack index width, plus one extra bit so that "full" (sp == DEPTH) is representable.
  localparam int SIW = $clog2(DEPTH);
  localparam int SPW = SIW + 1;

  localparam logic [AW-1:0]  LAST_ADDR = AW'(ELEMENTOS - 1);
  localparam logic [SPW-1:0] SP_FULL   = SPW'(DEPTH);

  // Action chosen for this cycle. Redirects take priority over stall.
  typedef enum logic [2:0] {
    ACT_FETCH,
    ACT_HOLD,
    ACT_CALL,
    ACT_RET,
    ACT_JUMP
  } action_e;

  // Address increment that wraps at the top of program memory.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + AW'(1);
  endfunction

  // Architectural state
  logic [AW-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [AW-1:0]    ir_pc_q, ir_pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Return-address stack storage and access
  logic [AW-1:0]  stk_q [DEPTH];
  logic           stk_full, stk_empty;
  logic [SIW-1:0] wr_idx, top_idx;
  logic [AW-1:0]  top_addr;
  logic           push_en;

  action_e act;

  assign stk_full  = (sp_q == SP_FULL);
  assign stk_empty = (sp_q == '0);
  assign wr_idx    = sp_q[SIW-1:0];
  assign top_idx   = SIW'(sp_q - SPW'(1));
  assign top_addr  = stk_q[top_idx];

  // Resolve the simultaneous requests into a single action: call > ret > jump > stall.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default value
    // first, so that no path leaves it unassigned and no latch is inferred.
    act = ACT_FETCH;
    if (call) begin
      act = ACT_CALL;
    end else if (ret) begin
      act = ACT_RET;
    end else if (jump) begin
      act = ACT_JUMP;
    end else if (stall) begin
      act = ACT_HOLD;
    end
  end

  // Next-state logic for PC, instruction register, stack pointer and sticky flags.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    ir_pc_d = ir_pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;

    unique case (act)
      ACT_CALL: begin
        pc_d    = target;
        instr_d = '0;
        valid_d = 1'b0;
        if (stk_full) begin
          ovf_d = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_d    = sp_q + SPW'(1);
        end
      end
      ACT_RET: begin
        instr_d = '0;
        valid_d = 1'b0;
        if (stk_empty) begin
          pc_d  = '0;
          unf_d = 1'b1;
        end else begin
          pc_d = top_addr;
          sp_d = sp_q - SPW'(1);
        end
      end
      ACT_JUMP: begin
        pc_d    = target;
        instr_d = '0;
        valid_d = 1'b0;
      end
      ACT_HOLD: begin
        // All fetch state keeps its value.
      end
      default: begin
        instr_d = mem_rd;
        ir_pc_d = pc_q;
        valid_d = 1'b1;
        pc_d    = addr_inc(pc_q);
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so that
    // every register samples the values from before this edge.
    if (!reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      ir_pc_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ir_pc_q <= ir_pc_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack entry write: push the return address (instruction after the call).
  always_ff @(posedge clk) begin
    // NOTE: stack entries are deliberately not reset; clearing sp empties the
    // stack, and an entry is always written before it can be read again.
    if (reset && push_en) begin
      stk_q[wr_idx] <= addr_inc(ir_pc_q);
    end
  end

  assign pc_addr       = pc_q;
  assign instr         = instr_q;
  assign instr_valid   = valid_q;
  assign ir_pc         = ir_pc_q;
  assign stk_overflow  = ovf_q;
  assign stk_underflow = unf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a behavioural reference model
// (queue-based stack) compared every cycle, and hand-computed spot checks.
module tb_fetch_unit;

  localparam int WIDTH     = 16;
  localparam int ELEMENTOS = 1024;
  localparam int DEPTH     = 8;
  localparam int AW        = $clog2(ELEMENTOS);

  logic             clk;
  logic             reset;
  logic [AW-1:0]    pc_addr;
  logic [WIDTH-1:0] mem_rd;
  logic             stall, jump, call, ret;
  logic [AW-1:0]    target;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic [AW-1:0]    ir_pc;
  logic             stk_overflow, stk_underflow;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.WIDTH(WIDTH), .ELEMENTOS(ELEMENTOS), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_addr      (pc_addr),
    .mem_rd       (mem_rd),
    .stall        (stall),
    .jump         (jump),
    .call         (call),
    .ret          (ret),
    .target       (target),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .ir_pc        (ir_pc),
    .stk_overflow (stk_overflow),
    .stk_underflow(stk_underflow)
  );

  // Program memory: word k holds k+100, read combinationally.
  logic [WIDTH-1:0] mem [ELEMENTOS];
  initial begin
    for (int k = 0; k < ELEMENTOS; k++) mem[k] = WIDTH'(k + 100);
  end
  assign mem_rd = mem[pc_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: spec-level behaviour with a queue as the LIFO.
  int m_pc, m_instr, m_irpc;
  bit m_valid, m_ovf, m_unf, m_ok;
  int m_stk [$];

  initial m_ok = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_pc = 0; m_instr = 0; m_valid = 0; m_irpc = 0; m_ovf = 0; m_unf = 0;
      m_stk.delete();
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (call) begin
        if (m_stk.size() < DEPTH) m_stk.push_back((m_irpc + 1) % ELEMENTOS);
        else m_ovf = 1;
        m_pc = target; m_instr = 0; m_valid = 0;
      end else if (ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = 0; m_unf = 1; end
        m_instr = 0; m_valid = 0;
      end else if (jump) begin
        m_pc = target; m_instr = 0; m_valid = 0;
      end else if (!stall) begin
        m_instr = (m_pc + 100) % (1 << WIDTH);
        m_irpc  = m_pc;
        m_valid = 1;
        m_pc    = (m_pc + 1) % ELEMENTOS;
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (m_ok) begin
      check("pc_addr",       32'(pc_addr),       32'(m_pc));
      check("instr",         32'(instr),         32'(m_instr));
      check("instr_valid",   32'(instr_valid),   32'(m_valid));
      check("ir_pc",         32'(ir_pc),         32'(m_irpc));
      check("stk_overflow",  32'(stk_overflow),  32'(m_ovf));
      check("stk_underflow", 32'(stk_underflow), 32'(m_unf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; jump = 0; call = 0; ret = 0;
  endtask

  int ret_exp [8] = '{161, 151, 141, 131, 121, 111, 101, 13};

  initial begin
    reset = 0; target = '0;
    idle();

    // Reset, then sequential run
    tick(); tick();
    check("rst_pc", 32'(pc_addr), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instr", 32'(instr), 0);
    reset = 1;
    tick();
    check("run1_instr", 32'(instr), 100);
    check("run1_irpc", 32'(ir_pc), 0);
    check("run1_valid", 32'(instr_valid), 1);
    check("run1_pc", 32'(pc_addr), 1);
    tick();
    check("run2_instr", 32'(instr), 101);
    check("run2_pc", 32'(pc_addr), 2);
    tick(); tick(); tick();
    check("run5_pc", 32'(pc_addr), 5);

    // Stall three cycles at pc=5
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_irpc", 32'(ir_pc), 4);
      check("stall_pc", 32'(pc_addr), 5);
      check("stall_instr", 32'(instr), 104);
    end
    stall = 0;
    tick();
    check("unstall_irpc", 32'(ir_pc), 5);
    tick(); tick();
    check("prejump_irpc", 32'(ir_pc), 7);

    // Jump to 200
    jump = 1; target = 200;
    tick();
    idle();
    check("jump_valid", 32'(instr_valid), 0);
    check("jump_instr", 32'(instr), 0);
    check("jump_pc", 32'(pc_addr), 200);
    check("jump_irpc_hold", 32'(ir_pc), 7);
    tick();
    check("jump_dest_instr", 32'(instr), 300);
    check("jump_dest_irpc", 32'(ir_pc), 200);
    check("jump_dest_valid", 32'(instr_valid), 1);

    // Call at ir_pc=10, return to 11
    jump = 1; target = 9;
    tick(); idle(); tick(); tick();
    check("precall_irpc", 32'(ir_pc), 10);
    call = 1; target = 50;
    tick(); idle();
    check("call_pc", 32'(pc_addr), 50);
    tick(); tick();
    ret = 1;
    tick(); idle();
    check("ret_pc", 32'(pc_addr), 11);
    check("ret_bubble", 32'(instr_valid), 0);
    tick();
    check("ret_irpc", 32'(ir_pc), 11);
    check("ret_instr", 32'(instr), 111);

    // Nested depth 3
    call = 1; target = 300; tick(); idle(); tick();
    call = 1; target = 400; tick(); idle(); tick();
    call = 1; target = 500; tick(); idle(); tick();
    ret = 1; tick(); idle();
    check("nest_ret1", 32'(pc_addr), 401);
    tick();
    ret = 1; tick(); idle();
    check("nest_ret2", 32'(pc_addr), 301);
    tick();
    ret = 1; tick(); idle();
    check("nest_ret3", 32'(pc_addr), 12);
    tick();

    // DEPTH+1 nested calls, then drain and underflow
    for (int i = 0; i <= DEPTH; i++) begin
      call = 1; target = AW'(100 + i * 10);
      tick(); idle();
      check("ovf_flag", 32'(stk_overflow), (i == DEPTH) ? 1 : 0);
      tick();
    end
    for (int j = 0; j < DEPTH; j++) begin
      ret = 1; tick(); idle();
      check("drain_pc", 32'(pc_addr), 32'(ret_exp[j]));
      tick();
    end
    check("pre_unf", 32'(stk_underflow), 0);
    ret = 1; tick(); idle();
    check("unf_pc", 32'(pc_addr), 0);
    check("unf_flag", 32'(stk_underflow), 1);
    tick();
    check("ovf_sticky", 32'(stk_overflow), 1);
    check("unf_sticky", 32'(stk_underflow), 1);

    // call+ret+jump together: call wins (ret on empty stack would give pc=0)
    call = 1; ret = 1; jump = 1; target = 77;
    tick(); idle();
    check("prio_pc", 32'(pc_addr), 77);
    tick();
    ret = 1; tick(); idle();
    check("prio_ret_pc", 32'(pc_addr), 1);
    tick();

    // PC wrap
    jump = 1; target = 1020;
    tick(); idle();
    tick(); tick(); tick(); tick();
    check("wrap_pc", 32'(pc_addr), 0);
    check("wrap_irpc", 32'(ir_pc), 1023);
    check("wrap_instr", 32'(instr), 1123);
    call = 1; target = 5;
    tick(); idle();
    tick();
    ret = 1; tick(); idle();
    check("wrap_push_ret", 32'(pc_addr), 0);
    tick();

    // Reset asserted mid-stall
    stall = 1;
    tick(); tick();
    reset = 0;
    tick();
    check("rst2_pc", 32'(pc_addr), 0);
    check("rst2_instr", 32'(instr), 0);
    check("rst2_valid", 32'(instr_valid), 0);
    check("rst2_irpc", 32'(ir_pc), 0);
    check("rst2_ovf", 32'(stk_overflow), 0);
    check("rst2_unf", 32'(stk_underflow), 0);
    reset = 1; stall = 0;
    tick();
    check("rst2_run_instr", 32'(instr), 100);
    check("rst2_run_valid", 32'(instr_valid), 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
